sar_adc_seq_ctrl: RTL and testbench
===================================

Name: sar_adc_seq_ctrl

Overview:
Parametrised successive-approximation ADC sequencer, the next generation of the fixed 10-bit ADC logic block in the user project area. It drives the capacitive DAC code and the sample switch, and reads the external comparator. It adds:
- configurable resolution;
- multi-channel mux select with round-robin scan;
- power-of-two oversampling/averaging;
- continuous conversion mode.

It sits inside the user project wrapper. Its ports map to io pads and logic-analyser bits.

Parameters:
RES, 10, conversion resolution in bits (4..16)
NCH, 4, number of analog mux channels (1..16); CHW = max(1, clog2(NCH))
SAMPLE_CYC, 4, clock cycles sample_o is held high per conversion (>=1)
AVG_LOG2, 0, log2 of conversions averaged per result (0..4); NAVG = 2^AVG_LOG2

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous reset, active-high
start_i  in  1  single-cycle request; accepted only in IDLE
cont_i  in  1  level; when high at result time, the next conversion starts automatically
scan_i  in  1  level; when high, the channel auto-increments after each result
ch_i  in  CHW  channel captured at accepted start
cmp_i  in  1  comparator: 1 = Vin >= DAC voltage
sample_o  out  1  sample switch enable
dac_o  out  RES  DAC trial code
ch_sel_o  out  CHW  analog mux select
data_o  out  RES  averaged result
data_ch_o  out  CHW  channel that produced data_o
valid_o  out  1  one-cycle result strobe
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values (any cycle wb_rst_i=1, including mid-conversion): all outputs 0, state IDLE, accumulator and counters 0. Reset has priority over every other input.
- States are IDLE, SAMPLE, CONVERT and DONE.
- IDLE:
  - start_i=1 latches ch_i into ch_sel_o and goes to SAMPLE.
  - start_i=0 stays in IDLE.
  - ch_i >= NCH is clamped to NCH-1.
- SAMPLE:
  - sample_o=1 and dac_o=0 for exactly SAMPLE_CYC cycles, then CONVERT.
- CONVERT:
  - Lasts RES cycles, MSB first. For trial bit k, dac_o holds the decided bits above k, bit k=1 and lower bits 0.
  - At the end-of-cycle edge, bit k <= cmp_i.
  - sample_o=0 throughout.
- After the LSB edge:
  - The final code (including the LSB decision) is added to an accumulator of width RES+AVG_LOG2, and the conversion count is incremented.
  - If count < NAVG: go to SAMPLE, same channel.
  - Otherwise: go to DONE.
- DONE (1 cycle):
  - data_o = accumulator >> AVG_LOG2 (truncating); data_ch_o = ch_sel_o; valid_o=1 for this cycle only.
  - Accumulator and count are cleared.
  - If scan_i=1, ch_sel_o advances, wrapping NCH-1 -> 0.
  - Next state: SAMPLE if cont_i=1, else IDLE. In continuous mode the advanced channel is used.
- Latency: valid_o is high in the cycle following edge number NAVG*(SAMPLE_CYC+RES), counting the start-accept edge as edge 0. Default parameters give 14.
- Result hold: data_o and data_ch_o hold their value until the next DONE.
- start_i while busy_o=1 is ignored; it is not queued.
- ch_i changes during a conversion have no effect.
- cont_i deasserted mid-conversion: the current result completes, then IDLE.
- NCH=1: ch_sel_o stays 0; scan has no effect.
- Arithmetic: the accumulator cannot overflow (NAVG*(2^RES-1) fits in RES+AVG_LOG2 bits). Full-scale codes 0 and 2^RES-1 must be reachable.

Test Plan:
1. Defaults; comparator model with Vin code 0x2A5 (cmp_i = Vin >= dac_o); start_i with ch_i=2 -> sample_o high 4 cycles, then dac_o trial 0x200, 0x300, 0x280, 0x2C0, ... Then valid_o 14 edges after accept, data_o=0x2A5, data_ch_o=2, busy_o back to 0 next cycle.
2. cmp_i tied 1 -> data_o=0x3FF; cmp_i tied 0 -> data_o=0x000; valid_o single-cycle each time.
3. AVG_LOG2=2; comparator model returns 100, 101, 102, 103 on successive conversions -> one valid_o after 56 edges, data_o=101 (406>>2).
4. cont_i=1, scan_i=1, NCH=4, start ch_i=3 -> valid_o every 15 cycles with data_ch_o 3,0,1,2,3; cont_i dropped mid-conversion -> that result still delivered, then IDLE.
5. start_i pulsed repeatedly during CONVERT -> ignored, exactly one result; ch_i=7 with NCH=4 -> ch_sel_o=3.
6. wb_rst_i asserted during CONVERT bit 5 -> next cycle all outputs 0, state IDLE. A start after release yields a normal full 14-edge conversion, with no residue from the old accumulator.

Source files
------------

// File: rtl/sar_adc_seq_ctrl_if.sv
// Handshake/data bundle between the SAR sequencer and its surroundings.
// The sequencer is the slave side; pads/LA logic is the master side.
interface sar_adc_seq_ctrl_if #(
  parameter int RES = 10,
  parameter int CHW = 2
);
  logic           start_i;
  logic           cont_i;
  logic           scan_i;
  logic [CHW-1:0] ch_i;
  logic           cmp_i;
  logic           sample_o;
  logic [RES-1:0] dac_o;
  logic [CHW-1:0] ch_sel_o;
  logic [RES-1:0] data_o;
  logic [CHW-1:0] data_ch_o;
  logic           valid_o;
  logic           busy_o;

  modport master (
    output start_i, cont_i, scan_i, ch_i, cmp_i,
    input  sample_o, dac_o, ch_sel_o,
    input  data_o, data_ch_o, valid_o, busy_o
  );

  modport slave (
    input  start_i, cont_i, scan_i, ch_i, cmp_i,
    output sample_o, dac_o, ch_sel_o,
    output data_o, data_ch_o, valid_o, busy_o
  );
endinterface

// File: rtl/sar_adc_seq_ctrl.sv
// SAR ADC sequencer: sample, MSB-first binary search, power-of-two
// averaging, multi-channel round-robin scan and continuous mode.
module sar_adc_seq_ctrl #(
  parameter int RES        = 10,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 4,
  parameter int AVG_LOG2   = 0,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  sar_adc_seq_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_CONV   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CMAX = (SAMPLE_CYC > RES) ? SAMPLE_CYC : RES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = RES + AVG_LOG2;
  localparam int NW   = AVG_LOG2 + 1;

  localparam logic [NW-1:0]  NAVG    = NW'(1) << AVG_LOG2;
  localparam logic [CW-1:0]  SC_LAST = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0]  BIT_TOP = CW'(RES - 1);
  localparam logic [CHW-1:0] CH_MAX  = CHW'(NCH - 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [RES-1:0] code_q, code_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [RES-1:0] data_q, data_d;
  logic [CHW-1:0] dch_q, dch_d;

  logic [RES-1:0] trial;
  logic [RES-1:0] code_fin;
  logic [AW-1:0]  acc_sum;
  logic [NW-1:0]  cnt_inc;
  logic [CHW-1:0] ch_clamp;

  // In CONVERT cyc_q is the index of the bit under trial
  assign trial    = RES'(1) << cyc_q;
  assign code_fin = bus.cmp_i ? (code_q | trial) : code_q;
  assign acc_sum  = acc_q + AW'(code_fin);
  assign cnt_inc  = cnt_q + NW'(1);
  assign ch_clamp = (int'(bus.ch_i) >= NCH) ? CH_MAX : bus.ch_i;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    data_d  = data_q;
    dch_d   = dch_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          ch_d    = ch_clamp;
          cyc_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cyc_q == SC_LAST) begin
          cyc_d   = BIT_TOP;
          code_d  = '0;
          state_d = S_CONV;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_CONV: begin
        code_d = code_fin;
        if (cyc_q == '0) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == NAVG) begin
            data_d  = RES'(acc_sum >> AVG_LOG2);
            dch_d   = ch_q;
            state_d = S_DONE;
          end else begin
            state_d = S_SAMPLE;
          end
        end else begin
          cyc_d = cyc_q - CW'(1);
        end
      end
      S_DONE: begin
        acc_d = '0;
        cnt_d = '0;
        cyc_d = '0;
        if (bus.scan_i) begin
          ch_d = (ch_q == CH_MAX) ? '0 : ch_q + CHW'(1);
        end
        state_d = bus.cont_i ? S_SAMPLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      code_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      dch_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      dch_q   <= dch_d;
    end
  end

  assign bus.sample_o  = (state_q == S_SAMPLE);
  assign bus.dac_o     = (state_q == S_CONV) ? (code_q | trial) : '0;
  assign bus.ch_sel_o  = ch_q;
  assign bus.data_o    = data_q;
  assign bus.data_ch_o = dch_q;
  assign bus.valid_o   = (state_q == S_DONE);
  assign bus.busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sar_adc_seq_ctrl.sv
// Directed bench: default-parameter sequencer plus an averaging,
// 3-channel instance, each fed by a behavioural comparator.
module tb_sar_adc_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  sar_adc_seq_ctrl_if #(.RES(10), .CHW(2)) ba ();
  sar_adc_seq_ctrl_if #(.RES(10), .CHW(2)) bb ();

  sar_adc_seq_ctrl u_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ba)
  );

  sar_adc_seq_ctrl #(
    .RES        (10),
    .NCH        (3),
    .SAMPLE_CYC (4),
    .AVG_LOG2   (2)
  ) u_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bb)
  );

  // A: 0 = Vin model, 1 = tied high, 2 = tied low
  int         cmode = 0;
  logic [9:0] vin_a = 10'h2A5;
  assign ba.cmp_i = (cmode == 0) ? (vin_a >= ba.dac_o)
                                 : (cmode == 1);

  // B: Vin steps 100,101,... on each new sample phase
  int bidx = 0;
  int bstart = 0;
  int vinb;
  always @(posedge bb.sample_o) bidx <= bidx + 1;
  assign vinb = 99 + bidx - bstart;
  assign bb.cmp_i = (int'(bb.dac_o) <= vinb);

  task automatic go_a(input logic [1:0] ch, input int n,
                      output int first, output int nv,
                      output logic [9:0] d,
                      output logic [1:0] dch);
    first = -1; nv = 0; d = 'x; dch = 'x;
    @(negedge clk);
    ba.ch_i = ch; ba.start_i = 1'b1;
    @(posedge clk); #1;
    ba.start_i = 1'b0;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (ba.valid_o) begin
        nv++;
        if (first < 0) first = e;
        d = ba.data_o; dch = ba.data_ch_o;
      end
    end
  endtask

  task automatic go_b(input logic [1:0] ch, input int n,
                      output int first, output int nv,
                      output logic [9:0] d,
                      output logic [1:0] dch);
    first = -1; nv = 0; d = 'x; dch = 'x;
    @(negedge clk);
    bstart = bidx;
    bb.ch_i = ch; bb.start_i = 1'b1;
    @(posedge clk); #1;
    bb.start_i = 1'b0;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (bb.valid_o) begin
        nv++;
        if (first < 0) first = e;
        d = bb.data_o; dch = bb.data_ch_o;
      end
    end
  endtask

  task automatic test_reset();
    logic [27:0] o;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    o = {ba.sample_o, ba.dac_o, ba.ch_sel_o, ba.data_o,
         ba.data_ch_o, ba.valid_o, ba.busy_o};
    total_cnt++;
    if (o !== '0) $display("FAIL reset_a: got %h want 0", o);
    else pass_cnt++;
    total_cnt++;
    if (bb.busy_o !== 1'b0)
      $display("FAIL reset_b_busy: got %b want 0", bb.busy_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] smp;
    logic [9:0] dv [0:7];
    int first, nv;
    logic [9:0] d;
    logic [1:0] dch;
    logic bsy15;
    cmode = 0; vin_a = 10'h2A5;
    first = -1; nv = 0; d = 'x; dch = 'x; bsy15 = 1'bx;
    @(negedge clk);
    ba.ch_i = 2'd2; ba.start_i = 1'b1;
    @(posedge clk); #1;
    ba.start_i = 1'b0; ba.ch_i = 2'd1;
    smp[4] = ba.sample_o; dv[0] = ba.dac_o;
    total_cnt++;
    if (ba.ch_sel_o !== 2'd2)
      $display("FAIL single_chsel: got %0d want 2", ba.ch_sel_o);
    else pass_cnt++;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e <= 4) smp[4-e] = ba.sample_o;
      if (e <= 7) dv[e] = ba.dac_o;
      if (e == 15) bsy15 = ba.busy_o;
      if (ba.valid_o) begin
        nv++;
        if (first < 0) first = e;
        d = ba.data_o; dch = ba.data_ch_o;
      end
    end
    total_cnt++;
    if (smp !== 5'b11110)
      $display("FAIL single_sample: got %b want 11110", smp);
    else pass_cnt++;
    total_cnt++;
    if (dv[0] !== 10'h000)
      $display("FAIL single_dac_smp: got %h want 000", dv[0]);
    else pass_cnt++;
    total_cnt++;
    if ({dv[4], dv[5], dv[6], dv[7]} !==
        {10'h200, 10'h300, 10'h280, 10'h2C0})
      $display("FAIL single_trials: got %h %h %h %h want 200 300 280 2c0",
               dv[4], dv[5], dv[6], dv[7]);
    else pass_cnt++;
    total_cnt++;
    if (first !== 14 || nv !== 1)
      $display("FAIL single_latency: got edge %0d x%0d want 14 x1",
               first, nv);
    else pass_cnt++;
    total_cnt++;
    if (d !== 10'h2A5 || dch !== 2'd2)
      $display("FAIL single_data: got %h ch %0d want 2a5 ch 2",
               d, dch);
    else pass_cnt++;
    total_cnt++;
    if (bsy15 !== 1'b0)
      $display("FAIL single_busy_end: got %b want 0", bsy15);
    else pass_cnt++;
    total_cnt++;
    if (ba.data_o !== 10'h2A5)
      $display("FAIL single_hold: got %h want 2a5", ba.data_o);
    else pass_cnt++;
  endtask

  task automatic test_fullscale();
    int first, nv;
    logic [9:0] d;
    logic [1:0] dch;
    cmode = 1;
    go_a(2'd0, 30, first, nv, d, dch);
    total_cnt++;
    if (d !== 10'h3FF || nv !== 1 || first !== 14)
      $display("FAIL full_high: got %h x%0d @%0d want 3ff x1 @14",
               d, nv, first);
    else pass_cnt++;
    cmode = 2;
    go_a(2'd1, 30, first, nv, d, dch);
    total_cnt++;
    if (d !== 10'h000 || nv !== 1 || first !== 14)
      $display("FAIL full_low: got %h x%0d @%0d want 000 x1 @14",
               d, nv, first);
    else pass_cnt++;
    cmode = 0;
  endtask

  task automatic test_continuous();
    int ve [0:7];
    logic [1:0] vc [0:7];
    int nv;
    for (int i = 0; i < 8; i++) begin ve[i] = -1; vc[i] = 'x; end
    nv = 0; cmode = 0; vin_a = 10'h2A5;
    @(negedge clk);
    ba.cont_i = 1'b1; ba.scan_i = 1'b1;
    ba.ch_i = 2'd3; ba.start_i = 1'b1;
    @(posedge clk); #1;
    ba.start_i = 1'b0;
    for (int e = 1; e <= 110; e++) begin
      @(posedge clk); #1;
      if (ba.valid_o) begin
        if (nv < 8) begin ve[nv] = e; vc[nv] = ba.data_ch_o; end
        nv++;
      end
      if (e == 80) ba.cont_i = 1'b0;
    end
    total_cnt++;
    if (nv !== 6)
      $display("FAIL cont_count: got %0d want 6", nv);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] ec;
      ec = 2'(3 + i);
      total_cnt++;
      if (ve[i] !== 14 + 15 * i || vc[i] !== ec)
        $display("FAIL cont_res%0d: got @%0d ch %0d want @%0d ch %0d",
                 i, ve[i], vc[i], 14 + 15 * i, ec);
      else pass_cnt++;
    end
    total_cnt++;
    if (ba.busy_o !== 1'b0 || ba.ch_sel_o !== 2'd1)
      $display("FAIL cont_stop: got busy %b ch %0d want 0 ch 1",
               ba.busy_o, ba.ch_sel_o);
    else pass_cnt++;
    ba.scan_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first, nv;
    logic [1:0] dch;
    first = -1; nv = 0; dch = 'x;
    vin_a = 10'h0F0;
    @(negedge clk);
    ba.ch_i = 2'd1; ba.start_i = 1'b1;
    @(posedge clk); #1;
    ba.start_i = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (ba.valid_o) begin
        nv++;
        if (first < 0) first = e;
        dch = ba.data_ch_o;
      end
      ba.start_i = (e == 3 || e == 6 || e == 9 || e == 14);
      ba.ch_i = 2'(e);
    end
    total_cnt++;
    if (nv !== 1 || first !== 14)
      $display("FAIL b2b_once: got x%0d @%0d want x1 @14", nv, first);
    else pass_cnt++;
    total_cnt++;
    if (dch !== 2'd1 || ba.busy_o !== 1'b0)
      $display("FAIL b2b_ch: got ch %0d busy %b want ch 1 busy 0",
               dch, ba.busy_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [27:0] o;
    int first, nv;
    logic [9:0] d;
    logic [1:0] dch;
    vin_a = 10'h2A5;
    @(negedge clk);
    ba.ch_i = 2'd2; ba.start_i = 1'b1;
    @(posedge clk); #1;
    ba.start_i = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    total_cnt++;
    if (ba.dac_o !== 10'h2A0)
      $display("FAIL rmid_bit5: got %h want 2a0", ba.dac_o);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    o = {ba.sample_o, ba.dac_o, ba.ch_sel_o, ba.data_o,
         ba.data_ch_o, ba.valid_o, ba.busy_o};
    total_cnt++;
    if (o !== '0) $display("FAIL rmid_zero: got %h want 0", o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    vin_a = 10'h15A;
    go_a(2'd3, 20, first, nv, d, dch);
    total_cnt++;
    if (first !== 14 || d !== 10'h15A || dch !== 2'd3)
      $display("FAIL rmid_after: got @%0d %h ch %0d want @14 15a ch 3",
               first, d, dch);
    else pass_cnt++;
  endtask

  task automatic test_avg();
    int first, nv;
    logic [9:0] d;
    logic [1:0] dch;
    @(negedge clk);
    bb.scan_i = 1'b1;
    go_b(2'd3, 70, first, nv, d, dch);
    total_cnt++;
    if (first !== 56 || nv !== 1)
      $display("FAIL avg_latency: got @%0d x%0d want @56 x1", first, nv);
    else pass_cnt++;
    total_cnt++;
    if (d !== 10'd101 || dch !== 2'd2)
      $display("FAIL avg_data: got %0d ch %0d want 101 ch 2", d, dch);
    else pass_cnt++;
    total_cnt++;
    if (bb.ch_sel_o !== 2'd0)
      $display("FAIL avg_wrap: got %0d want 0", bb.ch_sel_o);
    else pass_cnt++;
    bb.scan_i = 1'b0;
  endtask

  task automatic test_avg_reset();
    int first, nv;
    logic [9:0] d;
    logic [1:0] dch;
    @(negedge clk);
    bstart = bidx;
    bb.ch_i = 2'd0; bb.start_i = 1'b1;
    @(posedge clk); #1;
    bb.start_i = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bb.busy_o !== 1'b0 || bb.data_o !== 10'd0)
      $display("FAIL avgrst_zero: got busy %b data %0d want 0 0",
               bb.busy_o, bb.data_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    go_b(2'd1, 70, first, nv, d, dch);
    total_cnt++;
    if (first !== 56 || d !== 10'd101 || dch !== 2'd1)
      $display("FAIL avgrst_after: got @%0d %0d ch %0d want @56 101 ch 1",
               first, d, dch);
    else pass_cnt++;
  endtask

  initial begin
    ba.start_i = 1'b0; ba.cont_i = 1'b0;
    ba.scan_i = 1'b0; ba.ch_i = '0;
    bb.start_i = 1'b0; bb.cont_i = 1'b0;
    bb.scan_i = 1'b0; bb.ch_i = '0;
    test_reset();
    test_single();
    test_fullscale();
    test_continuous();
    test_back_to_back();
    test_reset_mid();
    test_avg();
    test_avg_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
